mc_control: RTL and testbench
=============================

Name: mc_control

Overview:
- Multi-cycle control FSM for the LEGv8 subset CPU.
- Consumes the 4-bit opcode from the instruction decoder and sequences the whole datapath: instruction fetch, register read, ALU, iterative multiplier, data memory and writeback.
- Owns the NZCV flag register and resolves B/CBZ/BLT.
- Sits between the decoder and the datapath muxes and enables.

Parameters:
- WAIT_LIMIT, 64, max cycles spent in any wait state (imem, dmem, multiplier) before trapping.
- CNT_W, 32, width of the retired-instruction counter.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous active-high reset
- opcode  in  4  decoded opcode: 0=undefined, 1 ADDI, 2 ADDS, 3 BLT, 4 B, 5 CBZ, 6 LDUR, 7 LSL, 8 LSR, 9 MUL, 10 STUR, 11 SUBS
- alu_zero  in  1  ALU result==0, valid in EXEC
- alu_flags  in  4  ALU NZCV (bit3=N, bit2=Z, bit1=C, bit0=V), valid in EXEC
- imem_ready  in  1  instruction word valid this cycle
- dmem_ready  in  1  data access complete this cycle
- mul_done  in  1  multiplier result valid (one-cycle pulse)
- imem_req  out  1  instruction fetch request
- ir_we  out  1  latch instruction register
- pc_we  out  1  update PC
- pc_branch  out  1  PC source: 1=PC+offset, 0=PC+4
- alu_op  out  3  0 ADD, 1 SUB, 2 LSL, 3 LSR, 4 PASS_B
- alu_src_imm  out  1  ALU B operand from immediate
- mul_start  out  1  one-cycle multiplier start pulse
- dmem_req  out  1  data memory request
- dmem_we  out  1  data memory write (STUR)
- mem_to_reg  out  1  writeback source is memory
- reg_we  out  1  register file write
- flags  out  4  architectural NZCV
- retire  out  1  one-cycle pulse per completed instruction
- retired_cnt  out  CNT_W  count of retired instructions
- trap  out  1  sticky fault indicator

Behaviour:
- Reset
  - state=FETCH, flags=0, retired_cnt=0, trap=0, wait counter=0.
  - During the reset cycle all strobes are 0. imem_req rises in the first cycle after reset deasserts.
  - Reset asserted mid-operation aborts any state immediately, including TRAP and the wait states.
- Output timing
  - Strobes decode from registered state (Moore).
  - pc_we/pc_branch in EXEC additionally depend on opcode, alu_zero and flags.
- FETCH
  - Hold imem_req=1 until imem_ready.
  - Cycle with imem_ready: ir_we=1, go to DECODE.
- DECODE
  - One cycle (register read).
  - opcode==0 or >11 -> TRAP; otherwise -> EXEC.
- EXEC (one cycle), by opcode:
  - ADDI: ADD, imm -> WB.
  - ADDS: ADD -> WB.
  - SUBS: SUB -> WB.
  - LSL/LSR: shift, imm -> WB.
  - ADDS/SUBS: flags <= alu_flags at end of EXEC. No other opcode writes flags.
  - LDUR/STUR: ADD, imm (address) -> MEM.
  - MUL: mul_start=1 -> MUL_WAIT.
  - B: pc_we=1, pc_branch=1 -> FETCH; retire.
  - CBZ: alu_op=PASS_B; pc_we=1; pc_branch=alu_zero -> FETCH; retire.
  - BLT: pc_we=1; pc_branch=flags.N ^ flags.V -> FETCH; retire.
- MEM
  - dmem_req=1 held until dmem_ready; dmem_we=1 iff STUR.
  - On dmem_ready: LDUR -> WB; STUR -> pc_we=1, pc_branch=0, retire, FETCH.
- MUL_WAIT
  - Wait for mul_done -> WB.
  - mul_start is never reasserted while waiting.
- WB
  - reg_we=1; mem_to_reg=1 iff LDUR.
  - pc_we=1, pc_branch=0, retire=1 -> FETCH.
- Wait counter
  - Clears on entry to FETCH, MEM and MUL_WAIT; increments each stalled cycle.
  - Reaching WAIT_LIMIT without ready/done -> TRAP.
  - A ready/done arriving in the same cycle as the limit wins.
- TRAP
  - trap=1, all strobes 0; held until reset.
- Retire
  - retired_cnt increments on each retire pulse and wraps modulo 2^CNT_W.
- Ignored inputs
  - imem_ready outside FETCH, dmem_ready outside MEM and mul_done outside MUL_WAIT are ignored.

Decomposition:
- Package mc_pkg holds:
  - opcode localparams (values above, replacing per-file defines);
  - alu_op encodings;
  - state enum (FETCH, DECODE, EXEC, MEM, MUL_WAIT, WB, TRAP);
  - NZCV bit indices.
- The decoder is to import the same package.
- One sub-module: mc_wait_timer, the saturating wait counter with clear/enable/expired.

Test Plan:
- Reset, then ADDS with alu_flags=4'b1000 and imem_ready after 2 stall cycles -> imem_req high 3 cycles; sequence FETCH, DECODE, EXEC, WB; flags=1000; one retire; retired_cnt=1.
- SUBS setting N=1,V=0, then BLT -> BLT cycle pc_we=1, pc_branch=1; repeat with N=1,V=1 -> pc_branch=0.
- LDUR with dmem_ready after 5 cycles -> dmem_req high 6 cycles, dmem_we=0; then WB with reg_we=1, mem_to_reg=1. STUR -> dmem_we=1, no reg_we, retire in MEM.
- MUL with mul_done 10 cycles after mul_start -> single mul_start pulse, reg_we one cycle after mul_done.
- opcode=0 after decode -> trap=1 the next cycle; no strobes for 20 cycles; reset -> FETCH, trap=0.
- dmem_ready never asserted with WAIT_LIMIT=64 -> trap after 64 stalled MEM cycles. Reset asserted during MUL_WAIT -> next cycle in FETCH with flags=0.

Source files
------------

// File: rtl/mc_pkg.sv
// Shared encodings for the LEGv8 multi-cycle control path: opcodes, ALU
// operations, control states and NZCV bit positions.
package mc_pkg;

    localparam logic [3:0] OP_UNDEF = 4'd0;
    localparam logic [3:0] OP_ADDI  = 4'd1;
    localparam logic [3:0] OP_ADDS  = 4'd2;
    localparam logic [3:0] OP_BLT   = 4'd3;
    localparam logic [3:0] OP_B     = 4'd4;
    localparam logic [3:0] OP_CBZ   = 4'd5;
    localparam logic [3:0] OP_LDUR  = 4'd6;
    localparam logic [3:0] OP_LSL   = 4'd7;
    localparam logic [3:0] OP_LSR   = 4'd8;
    localparam logic [3:0] OP_MUL   = 4'd9;
    localparam logic [3:0] OP_STUR  = 4'd10;
    localparam logic [3:0] OP_SUBS  = 4'd11;

    localparam logic [2:0] ALU_ADD    = 3'd0;
    localparam logic [2:0] ALU_SUB    = 3'd1;
    localparam logic [2:0] ALU_LSL    = 3'd2;
    localparam logic [2:0] ALU_LSR    = 3'd3;
    localparam logic [2:0] ALU_PASS_B = 3'd4;

    localparam int unsigned FLAG_N = 3;
    localparam int unsigned FLAG_Z = 2;
    localparam int unsigned FLAG_C = 1;
    localparam int unsigned FLAG_V = 0;

    typedef enum logic [2:0] {
        FETCH,
        DECODE,
        EXEC,
        MEM,
        MUL_WAIT,
        WB,
        TRAP
    } state_t;

    function automatic logic op_valid(input logic [3:0] op);
        return (op != OP_UNDEF) && (op <= OP_SUBS);
    endfunction

endpackage

// File: rtl/mc_wait_timer.sv
// Saturating stall counter shared by the fetch, memory and multiplier waits.
module mc_wait_timer #(
    parameter int unsigned LIMIT = 64
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int unsigned W = $clog2(LIMIT + 1);

    logic [W-1:0] count;

    // Count stalled cycles, saturating one short of the limit.
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            count <= '0;
        end else if (enable && (count < W'(LIMIT - 1))) begin
            count <= count + W'(1);
        end
    end

    // Asserted when one more stalled cycle would exhaust the budget; the
    // caller qualifies it with its own stall condition so a ready/done that
    // arrives on the final cycle still wins.
    always_comb begin
        expired = (count == W'(LIMIT - 1));
    end

endmodule

// File: rtl/mc_control.sv
// Multi-cycle control FSM for the LEGv8 subset CPU: sequences fetch, decode,
// execute, memory, multiply and writeback, and owns the NZCV flags.
module mc_control
    import mc_pkg::*;
#(
    parameter int unsigned WAIT_LIMIT = 64,
    parameter int unsigned CNT_W      = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [3:0]       opcode,
    input  logic             alu_zero,
    input  logic [3:0]       alu_flags,
    input  logic             imem_ready,
    input  logic             dmem_ready,
    input  logic             mul_done,
    output logic             imem_req,
    output logic             ir_we,
    output logic             pc_we,
    output logic             pc_branch,
    output logic [2:0]       alu_op,
    output logic             alu_src_imm,
    output logic             mul_start,
    output logic             dmem_req,
    output logic             dmem_we,
    output logic             mem_to_reg,
    output logic             reg_we,
    output logic [3:0]       flags,
    output logic             retire,
    output logic [CNT_W-1:0] retired_cnt,
    output logic             trap
);

    state_t state, next_state;
    logic   stall;
    logic   expired;

    mc_wait_timer #(.LIMIT(WAIT_LIMIT)) u_wait_timer (
        .clk     (clk),
        .reset   (reset),
        .clear   (next_state != state),
        .enable  (stall),
        .expired (expired)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= FETCH;
        end else begin
            state <= next_state;
        end
    end

    // Architectural flags and retired-instruction counter.
    always_ff @(posedge clk) begin
        if (reset) begin
            flags       <= '0;
            retired_cnt <= '0;
        end else begin
            if ((state == EXEC) && ((opcode == OP_ADDS) || (opcode == OP_SUBS))) begin
                flags <= alu_flags;
            end
            if (retire) begin
                retired_cnt <= retired_cnt + CNT_W'(1);
            end
        end
    end

    // Next-state and strobe decode; everything is held low while in reset.
    always_comb begin
        next_state  = state;
        stall       = 1'b0;
        imem_req    = 1'b0;
        ir_we       = 1'b0;
        pc_we       = 1'b0;
        pc_branch   = 1'b0;
        alu_op      = ALU_ADD;
        alu_src_imm = 1'b0;
        mul_start   = 1'b0;
        dmem_req    = 1'b0;
        dmem_we     = 1'b0;
        mem_to_reg  = 1'b0;
        reg_we      = 1'b0;
        retire      = 1'b0;
        trap        = 1'b0;
        if (!reset) begin
            case (state)
                FETCH: begin
                    imem_req = 1'b1;
                    if (imem_ready) begin
                        ir_we      = 1'b1;
                        next_state = DECODE;
                    end else begin
                        stall = 1'b1;
                        if (expired) next_state = TRAP;
                    end
                end
                DECODE: begin
                    next_state = op_valid(opcode) ? EXEC : TRAP;
                end
                EXEC: begin
                    next_state = WB;
                    case (opcode)
                        OP_ADDI: alu_src_imm = 1'b1;
                        OP_ADDS: alu_op = ALU_ADD;
                        OP_SUBS: alu_op = ALU_SUB;
                        OP_LSL: begin
                            alu_op      = ALU_LSL;
                            alu_src_imm = 1'b1;
                        end
                        OP_LSR: begin
                            alu_op      = ALU_LSR;
                            alu_src_imm = 1'b1;
                        end
                        OP_LDUR, OP_STUR: begin
                            alu_src_imm = 1'b1;
                            next_state  = MEM;
                        end
                        OP_MUL: begin
                            mul_start  = 1'b1;
                            next_state = MUL_WAIT;
                        end
                        OP_B: begin
                            pc_we      = 1'b1;
                            pc_branch  = 1'b1;
                            retire     = 1'b1;
                            next_state = FETCH;
                        end
                        OP_CBZ: begin
                            alu_op     = ALU_PASS_B;
                            pc_we      = 1'b1;
                            pc_branch  = alu_zero;
                            retire     = 1'b1;
                            next_state = FETCH;
                        end
                        OP_BLT: begin
                            pc_we      = 1'b1;
                            pc_branch  = flags[FLAG_N] ^ flags[FLAG_V];
                            retire     = 1'b1;
                            next_state = FETCH;
                        end
                        default: next_state = TRAP;
                    endcase
                end
                MEM: begin
                    dmem_req = 1'b1;
                    dmem_we  = (opcode == OP_STUR);
                    if (dmem_ready) begin
                        if (opcode == OP_STUR) begin
                            pc_we      = 1'b1;
                            retire     = 1'b1;
                            next_state = FETCH;
                        end else begin
                            next_state = WB;
                        end
                    end else begin
                        stall = 1'b1;
                        if (expired) next_state = TRAP;
                    end
                end
                MUL_WAIT: begin
                    if (mul_done) begin
                        next_state = WB;
                    end else begin
                        stall = 1'b1;
                        if (expired) next_state = TRAP;
                    end
                end
                WB: begin
                    reg_we     = 1'b1;
                    mem_to_reg = (opcode == OP_LDUR);
                    pc_we      = 1'b1;
                    retire     = 1'b1;
                    next_state = FETCH;
                end
                TRAP: begin
                    trap = 1'b1;
                end
                default: next_state = TRAP;
            endcase
        end
    end

endmodule

// File: tb/tb_mc_control.sv
// Scoreboard bench for mc_control: the driver predicts each instruction's
// externally visible behaviour and queues it; the monitor gathers the strobes
// seen between retire/trap events and compares against the queue head.
module tb_mc_control;

    localparam int unsigned WL = 64;
    localparam int unsigned CW = 32;

    localparam logic [3:0] ADDI = 1, ADDS = 2, BLT = 3, B = 4, CBZ = 5, LDUR = 6,
                           LSL = 7, LSR = 8, MUL = 9, STUR = 10, SUBS = 11;

    logic          clk = 1'b0;
    logic          reset;
    logic [3:0]    opcode, alu_flags;
    logic          alu_zero, imem_ready, dmem_ready, mul_done;
    logic          imem_req, ir_we, pc_we, pc_branch, alu_src_imm, mul_start;
    logic          dmem_req, dmem_we, mem_to_reg, reg_we, retire, trap;
    logic [2:0]    alu_op;
    logic [3:0]    flags;
    logic [CW-1:0] retired_cnt;

    mc_control #(.WAIT_LIMIT(WL), .CNT_W(CW)) dut (
        .clk(clk), .reset(reset), .opcode(opcode), .alu_zero(alu_zero),
        .alu_flags(alu_flags), .imem_ready(imem_ready), .dmem_ready(dmem_ready),
        .mul_done(mul_done), .imem_req(imem_req), .ir_we(ir_we), .pc_we(pc_we),
        .pc_branch(pc_branch), .alu_op(alu_op), .alu_src_imm(alu_src_imm),
        .mul_start(mul_start), .dmem_req(dmem_req), .dmem_we(dmem_we),
        .mem_to_reg(mem_to_reg), .reg_we(reg_we), .flags(flags), .retire(retire),
        .retired_cnt(retired_cnt), .trap(trap)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          is_trap;
        int          imem;
        int          dmem;
        bit          we;
        int          regwe;
        bit          m2r;
        int          mstart;
        int          pcwe;
        bit          br;
        bit          chk_aop;
        logic [2:0]  aop;
        bit          chk_imm;
        bit          imm;
        logic [3:0]  fl;
        int unsigned cnt_before;
    } exp_t;

    exp_t        q[$];
    int          checks = 0;
    int          errors = 0;
    logic [3:0]  mflags = '0;
    int unsigned mcnt = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    // Reference model: per-instruction observable behaviour from the ISA rules.
    task automatic predict(input logic [3:0] op, input logic [3:0] af, input bit az,
                           input int si, input int sd, input bit is_trap, input int dm);
        exp_t e;
        e.is_trap = is_trap;
        e.imem    = si + 1;
        e.dmem    = (op == LDUR || op == STUR) ? sd + 1 : 0;
        e.we      = (op == STUR);
        e.regwe   = (op inside {ADDI, ADDS, SUBS, LSL, LSR, LDUR, MUL}) ? 1 : 0;
        e.m2r     = (op == LDUR);
        e.mstart  = (op == MUL) ? 1 : 0;
        e.pcwe    = 1;
        e.br      = (op == B) ? 1'b1 : (op == CBZ) ? az :
                    (op == BLT) ? (mflags[3] != mflags[0]) : 1'b0;
        e.chk_aop = 1'b1;
        e.chk_imm = 1'b1;
        e.aop     = 3'd0;
        e.imm     = 1'b0;
        case (op)
            ADDI:       e.imm = 1'b1;
            SUBS:       e.aop = 3'd1;
            LSL:        begin e.aop = 3'd2; e.imm = 1'b1; end
            LSR:        begin e.aop = 3'd3; e.imm = 1'b1; end
            LDUR, STUR: e.imm = 1'b1;
            CBZ:        begin e.aop = 3'd4; e.chk_imm = 1'b0; end
            B, BLT, MUL: begin e.chk_aop = 1'b0; e.chk_imm = 1'b0; end
            default: ;
        endcase
        if (is_trap) begin
            e.dmem = dm;
            e.regwe = 0;
            e.pcwe = 0;
            e.mstart = 0;
        end else begin
            if (op == ADDS || op == SUBS) mflags = af;
        end
        e.fl = mflags;
        e.cnt_before = mcnt;
        if (!is_trap) mcnt++;
        q.push_back(e);
    endtask

    // Monitor: accumulate strobes per instruction and score on retire/trap.
    int   a_imem, a_dmem, a_regwe, a_mstart, a_pcwe, phase;
    bit   a_we, a_m2r, a_br, a_imm, trap_seen;
    logic [2:0] a_aop;

    task automatic clear_acc();
        a_imem = 0; a_dmem = 0; a_regwe = 0; a_mstart = 0; a_pcwe = 0; phase = 0;
        a_we = 0; a_m2r = 0; a_br = 0; a_imm = 0; a_aop = 3'd7;
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (reset) begin
            clear_acc();
            trap_seen = 0;
        end else if (trap) begin
            chk("trap_quiet", {imem_req, ir_we, pc_we, pc_branch, mul_start, dmem_req,
                               dmem_we, mem_to_reg, reg_we, retire}, 0);
            if (!trap_seen) begin
                trap_seen = 1;
                if (q.size() == 0) chk("scoreboard_nonempty_trap", 0, 1);
                else begin
                    e = q.pop_front();
                    chk("event_is_trap", e.is_trap, 1);
                    chk("trap_imem_cycles", a_imem, e.imem);
                    chk("trap_dmem_cycles", a_dmem, e.dmem);
                    chk("trap_mul_start", a_mstart, e.mstart);
                    chk("trap_reg_we", a_regwe, e.regwe);
                    chk("trap_pc_we", a_pcwe, e.pcwe);
                    chk("trap_flags", flags, e.fl);
                end
                clear_acc();
            end
        end else begin
            if (imem_req)  a_imem++;
            if (dmem_req)  a_dmem++;
            if (dmem_we)   a_we = 1;
            if (reg_we)    a_regwe++;
            if (mem_to_reg) a_m2r = 1;
            if (mul_start) a_mstart++;
            if (pc_we) begin a_pcwe++; a_br = pc_branch; end
            if (phase == 2) begin a_aop = alu_op; a_imm = alu_src_imm; phase = 0; end
            else if (phase == 1) phase = 2;
            if (ir_we) phase = 1;
            if (retire) begin
                if (q.size() == 0) chk("scoreboard_nonempty_retire", 0, 1);
                else begin
                    e = q.pop_front();
                    chk("event_is_retire", e.is_trap, 0);
                    chk("imem_cycles", a_imem, e.imem);
                    chk("dmem_cycles", a_dmem, e.dmem);
                    chk("dmem_we", a_we, e.we);
                    chk("reg_we_cycles", a_regwe, e.regwe);
                    chk("mem_to_reg", a_m2r, e.m2r);
                    chk("mul_start_pulses", a_mstart, e.mstart);
                    chk("pc_we_cycles", a_pcwe, e.pcwe);
                    chk("pc_branch", a_br, e.br);
                    if (e.chk_aop) chk("alu_op", a_aop, e.aop);
                    if (e.chk_imm) chk("alu_src_imm", a_imm, e.imm);
                    chk("flags", flags, e.fl);
                    chk("retired_cnt", retired_cnt, e.cnt_before);
                end
                clear_acc();
            end
        end
    end

    // Driver helpers: inputs change 1 time unit after the rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic probe(input int sel);
        case (sel)
            0: return imem_req;
            1: return dmem_req;
            2: return mul_start;
            3: return retire;
            default: return trap;
        endcase
    endfunction

    task automatic wait_for(input int sel, input int limit, input string name);
        int n = 0;
        while (probe(sel) !== 1'b1 && n < limit) begin
            step();
            n++;
        end
        chk(name, probe(sel), 1);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        imem_ready = 0; dmem_ready = 0; mul_done = 0;
        q.delete();
        mflags = '0;
        mcnt = 0;
        step();
        chk("rst_imem_req", imem_req, 0);
        chk("rst_strobes", {ir_we, pc_we, mul_start, dmem_req, reg_we, retire}, 0);
        chk("rst_trap", trap, 0);
        chk("rst_flags", flags, 0);
        chk("rst_retired_cnt", retired_cnt, 0);
        reset = 1'b0;
        #1;
        chk("post_rst_imem_req", imem_req, 1);
        chk("post_rst_trap", trap, 0);
    endtask

    task automatic do_fetch(input int si);
        wait_for(0, 200, "fetch_req_seen");
        repeat (si) begin
            imem_ready = 0;
            dmem_ready = 1'($urandom_range(0, 1));
            mul_done   = 1'($urandom_range(0, 1));
            step();
        end
        imem_ready = 1; dmem_ready = 0; mul_done = 0;
        step();
        imem_ready = 0;
    endtask

    task automatic run_instr(input logic [3:0] op, input logic [3:0] af, input bit az,
                             input int si, input int sd, input int ml);
        opcode = op; alu_flags = af; alu_zero = az;
        predict(op, af, az, si, sd, 1'b0, 0);
        do_fetch(si);
        if (op == LDUR || op == STUR) begin
            wait_for(1, 10, "dmem_req_seen");
            repeat (sd) begin
                dmem_ready = 0;
                imem_ready = 1'($urandom_range(0, 1));
                mul_done   = 1'($urandom_range(0, 1));
                step();
            end
            imem_ready = 0; mul_done = 0; dmem_ready = 1;
            step();
            dmem_ready = 0;
        end else if (op == MUL) begin
            wait_for(2, 10, "mul_start_seen");
            repeat (ml) begin
                imem_ready = 1'($urandom_range(0, 1));
                dmem_ready = 1'($urandom_range(0, 1));
                step();
            end
            imem_ready = 0; dmem_ready = 0; mul_done = 1;
            step();
            mul_done = 0;
        end
        if (op != STUR) begin
            wait_for(3, 10, "retire_seen");
            step();
        end
    endtask

    task automatic run_trap(input logic [3:0] op, input int si, input bit imem_hang,
                            input bit dmem_hang);
        opcode = op; alu_flags = 4'hF; alu_zero = 0;
        if (imem_hang) begin
            predict(op, 4'hF, 0, WL - 1, 0, 1'b1, 0);
            wait_for(4, 200, "imem_timeout_trap");
        end else begin
            predict(op, 4'hF, 0, si, 0, 1'b1, dmem_hang ? WL : 0);
            do_fetch(si);
            wait_for(4, 200, "trap_seen");
        end
        repeat (20) step();
        chk("trap_sticky", trap, 1);
        do_reset();
    endtask

    initial begin
        logic [3:0] ops[11] = '{ADDI, ADDS, BLT, B, CBZ, LDUR, LSL, LSR, MUL, STUR, SUBS};
        reset = 1; opcode = 0; alu_flags = 0; alu_zero = 0;
        imem_ready = 0; dmem_ready = 0; mul_done = 0;
        clear_acc();
        trap_seen = 0;
        do_reset();

        run_instr(ADDS, 4'b1000, 0, 2, 0, 0);
        run_instr(SUBS, 4'b1000, 0, 0, 0, 0);
        run_instr(BLT,  4'b0000, 0, 1, 0, 0);
        run_instr(SUBS, 4'b1001, 0, 0, 0, 0);
        run_instr(BLT,  4'b1000, 0, 0, 0, 0);
        run_instr(LDUR, 4'b1111, 0, 0, 5, 0);
        run_instr(STUR, 4'b1111, 0, 1, 2, 0);
        run_instr(MUL,  4'b0110, 0, 0, 0, 10);
        run_instr(B,    4'b0000, 0, 0, 0, 0);
        run_instr(CBZ,  4'b0000, 1, 0, 0, 0);
        run_instr(CBZ,  4'b0000, 0, 0, 0, 0);
        run_instr(ADDI, 4'b0101, 0, 0, 0, 0);
        run_instr(LSL,  4'b0101, 0, 0, 0, 0);
        run_instr(LSR,  4'b0101, 0, 0, 0, 0);
        run_instr(LDUR, 4'b0000, 0, WL - 1, WL - 1, 0);
        run_instr(MUL,  4'b0000, 0, 0, 0, WL);

        for (int i = 0; i < 120; i++) begin
            run_instr(ops[$urandom_range(0, 10)], 4'($urandom), 1'($urandom),
                      ($urandom_range(0, 7) == 0) ? $urandom_range(0, 12) : $urandom_range(0, 2),
                      $urandom_range(0, 6), $urandom_range(1, 12));
        end

        run_trap(4'd0, 1, 0, 0);
        run_trap(4'd13, 0, 0, 0);
        run_trap(LDUR, 0, 0, 1);
        run_trap(ADDI, 0, 1, 0);

        run_instr(ADDS, 4'b0101, 0, 0, 0, 0);
        opcode = MUL;
        predict(MUL, 0, 0, 0, 0, 1'b0, 0);
        do_fetch(0);
        wait_for(2, 10, "mul_start_seen");
        repeat (3) step();
        chk("pre_reset_flags", flags, 4'b0101);
        do_reset();

        run_instr(ADDI, 0, 0, 0, 0, 0);
        repeat (4) step();
        chk("queue_drained", q.size(), 0);
        chk("final_retired_cnt", retired_cnt, mcnt);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: actual=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
